// File: rtl/c64_dma_bus_master_if.sv
// Bus bundle between dma_engine, the C64 expansion port and c64_dma_bus_master.
// The master modport is the bus-master side; the slave modport is the environment side.
interface c64_dma_bus_master_if;
   logic [15:0] dma_a;
   logic [7:0]  dma_d;
   logic        dma_rw;
   logic        dma_req;
   logic        dma_ack;
   logic [7:0]  dma_q;
   logic        phi2;
   logic        ba;
   logic        dma_n;
   logic [15:0] bus_a_out;
   logic        bus_a_oe;
   logic        bus_rw_out;
   logic [7:0]  bus_d_out;
   logic        bus_d_oe;
   logic [7:0]  bus_d_in;

   modport master (
      input  dma_a, dma_d, dma_rw, dma_req, phi2, ba, bus_d_in,
      output dma_ack, dma_q, dma_n, bus_a_out, bus_a_oe, bus_rw_out, bus_d_out, bus_d_oe
   );

   modport slave (
      output dma_a, dma_d, dma_rw, dma_req, phi2, ba, bus_d_in,
      input  dma_ack, dma_q, dma_n, bus_a_out, bus_a_oe, bus_rw_out, bus_d_out, bus_d_oe
   );
endinterface

// File: rtl/c64_dma_bus_master.sv
// Runs single phi2-aligned C64 expansion-port bus cycles for dma_engine using a
// req/ack toggle handshake, keeping the bus (dma_n low) between close requests.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | dma_n released, drivers off, waiting for a request
// ARM       | dma_n low, counting phi2 falls until the CPU is safely halted
// WAIT_RISE | waiting for a phi2 rise with BA high to start the bus cycle
// CYCLE     | address (and write data) driven for the phi2 high phase
// HOLD      | bus kept after a transfer; releases after HOLD_CLKS idle clks
module c64_dma_bus_master #(
   parameter int ARM_CYCLES  = 3,
   parameter int SAMPLE_CLKS = 20,
   parameter int HOLD_CLKS   = 64
) (
   input logic                  clk,
   input logic                  reset,
   c64_dma_bus_master_if.master bus
);
   typedef enum logic [2:0] {IDLE, ARM, WAIT_RISE, CYCLE, HOLD} state_t;

   localparam logic [7:0] ARM_LAST  = 8'(ARM_CYCLES);
   localparam logic [7:0] SAMPLE_AT = 8'(SAMPLE_CLKS - 1);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CLKS);

   state_t      state, state_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic        captured, captured_nxt;
   logic        phi2_s1, phi2_s2, phi2_d, ba_s1, ba_s2;
   logic        rise, fall, pending;

   logic        dma_n_q, dma_n_nxt;
   logic [15:0] a_out_q, a_out_nxt;
   logic        a_oe_q, a_oe_nxt;
   logic        rw_out_q, rw_out_nxt;
   logic [7:0]  d_out_q, d_out_nxt;
   logic        d_oe_q, d_oe_nxt;
   logic [7:0]  q_q, q_nxt;
   logic        ack_q, ack_nxt;

   assign rise    = phi2_s2 & ~phi2_d;
   assign fall    = ~phi2_s2 & phi2_d;
   assign pending = bus.dma_req != ack_q;

   assign bus.dma_n      = dma_n_q;
   assign bus.bus_a_out  = a_out_q;
   assign bus.bus_a_oe   = a_oe_q;
   assign bus.bus_rw_out = rw_out_q;
   assign bus.bus_d_out  = d_out_q;
   assign bus.bus_d_oe   = d_oe_q;
   assign bus.dma_q      = q_q;
   assign bus.dma_ack    = ack_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phi2_s1  <= 1'b0;
         phi2_s2  <= 1'b0;
         phi2_d   <= 1'b0;
         ba_s1    <= 1'b0;
         ba_s2    <= 1'b0;
         state    <= IDLE;
         cnt      <= 8'd0;
         captured <= 1'b0;
         dma_n_q  <= 1'b1;
         a_out_q  <= 16'd0;
         a_oe_q   <= 1'b0;
         rw_out_q <= 1'b1;
         d_out_q  <= 8'd0;
         d_oe_q   <= 1'b0;
         q_q      <= 8'd0;
         ack_q    <= 1'b0;
      end else begin
         phi2_s1  <= bus.phi2;
         phi2_s2  <= phi2_s1;
         phi2_d   <= phi2_s2;
         ba_s1    <= bus.ba;
         ba_s2    <= ba_s1;
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         captured <= captured_nxt;
         dma_n_q  <= dma_n_nxt;
         a_out_q  <= a_out_nxt;
         a_oe_q   <= a_oe_nxt;
         rw_out_q <= rw_out_nxt;
         d_out_q  <= d_out_nxt;
         d_oe_q   <= d_oe_nxt;
         q_q      <= q_nxt;
         ack_q    <= ack_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      captured_nxt = captured;
      dma_n_nxt    = dma_n_q;
      a_out_nxt    = a_out_q;
      a_oe_nxt     = a_oe_q;
      rw_out_nxt   = rw_out_q;
      d_out_nxt    = d_out_q;
      d_oe_nxt     = d_oe_q;
      q_nxt        = q_q;
      ack_nxt      = ack_q;
      case (state)
         IDLE: begin
            dma_n_nxt = 1'b1;
            a_oe_nxt  = 1'b0;
            d_oe_nxt  = 1'b0;
            if (pending) begin
               dma_n_nxt = 1'b0;
               cnt_nxt   = 8'd0;
               state_nxt = ARM;
            end
         end
         ARM: begin
            if (fall) begin
               cnt_nxt = cnt + 8'd1;
               if (cnt + 8'd1 == ARM_LAST) state_nxt = WAIT_RISE;
            end
         end
         WAIT_RISE: begin
            if (rise && ba_s2) begin
               a_out_nxt  = bus.dma_a;
               rw_out_nxt = ~bus.dma_rw;
               a_oe_nxt   = 1'b1;
               if (bus.dma_rw) begin
                  d_out_nxt = bus.dma_d;
                  d_oe_nxt  = 1'b1;
               end
               cnt_nxt      = 8'd0;
               captured_nxt = 1'b0;
               state_nxt    = CYCLE;
            end
         end
         CYCLE: begin
            if (cnt != 8'hFF) cnt_nxt = cnt + 8'd1;
            // An early phi2 fall forces the read capture so dma_q is valid at ack.
            if (rw_out_q && !captured && (fall || cnt == SAMPLE_AT)) begin
               q_nxt        = bus.bus_d_in;
               captured_nxt = 1'b1;
            end
            if (fall) begin
               a_oe_nxt  = 1'b0;
               d_oe_nxt  = 1'b0;
               ack_nxt   = ~ack_q;
               cnt_nxt   = 8'd0;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (pending) begin
               state_nxt = WAIT_RISE;
            end else begin
               cnt_nxt = cnt + 8'd1;
               if (cnt + 8'd1 == HOLD_LAST) begin
                  dma_n_nxt = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_c64_dma_bus_master.sv
// Directed bench for c64_dma_bus_master: 50 MHz clk, 1 MHz phi2, hand-computed expectations.
`timescale 1ns/1ps
module tb_c64_dma_bus_master;
   logic clk;
   logic reset;
   c64_dma_bus_master_if bus_if();

   c64_dma_bus_master dut (.clk(clk), .reset(reset), .bus(bus_if));

   int vectors = 0;
   int miscompares = 0;
   int fall_cnt = 0;
   int rise_cnt = 0;
   logic exp_ack = 1'b0;
   int b_f, b_r;

   // transfer observation results
   bit   r_ok;
   int   r_oe_clks, r_doe_clks, r_falls, r_rises, r_nhigh, r_clks, r_rel;
   logic r_rw, r_ack_oe, r_prev_oe;
   logic [15:0] r_aout;
   logic [7:0]  r_dout;

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // phi2 edges offset from clk edges so sampling is race-free
   initial begin
      bus_if.phi2 = 1'b0;
      #3;
      forever #500 bus_if.phi2 = ~bus_if.phi2;
   end

   always @(posedge bus_if.phi2) rise_cnt <= rise_cnt + 1;
   always @(negedge bus_if.phi2) fall_cnt <= fall_cnt + 1;

   task automatic start_aligned();
      @(posedge bus_if.phi2);
      @(negedge clk);
      b_f = fall_cnt;
      b_r = rise_cnt;
      bus_if.dma_req = ~bus_if.dma_req;
      exp_ack = ~exp_ack;
   endtask

   task automatic toggle_req_now();
      b_f = fall_cnt;
      b_r = rise_cnt;
      bus_if.dma_req = ~bus_if.dma_req;
      exp_ack = ~exp_ack;
   endtask

   task automatic run_transfer(input int max_clks);
      logic ack0;
      logic prev_oe;
      bit   seen;
      ack0 = bus_if.dma_ack;
      r_ok = 0; r_oe_clks = 0; r_doe_clks = 0; r_falls = -1; r_rises = -1;
      r_nhigh = 0; r_clks = 0; r_rw = 1'bx; r_aout = 16'hxxxx; r_dout = 8'hxx;
      r_ack_oe = 1'bx; r_prev_oe = 1'bx; seen = 0; prev_oe = 1'b0;
      while (r_clks < max_clks) begin
         @(negedge clk);
         r_clks++;
         if (bus_if.dma_n !== 1'b0) r_nhigh++;
         if (bus_if.dma_ack !== ack0) begin
            r_ok = 1;
            r_ack_oe = bus_if.bus_a_oe | bus_if.bus_d_oe;
            r_prev_oe = prev_oe;
            break;
         end
         if (bus_if.bus_a_oe === 1'b1) begin
            r_oe_clks++;
            r_rw = bus_if.bus_rw_out;
            r_aout = bus_if.bus_a_out;
            if (!seen) begin
               seen = 1;
               r_falls = fall_cnt - b_f;
               r_rises = rise_cnt - b_r;
               bus_if.dma_a = ~bus_if.dma_a;
               bus_if.dma_d = ~bus_if.dma_d;
            end
         end
         if (bus_if.bus_d_oe === 1'b1) begin
            r_doe_clks++;
            r_dout = bus_if.bus_d_out;
         end
         prev_oe = bus_if.bus_a_oe;
      end
   endtask

   task automatic wait_release(input int max_clks);
      r_rel = -1;
      for (int i = 1; i <= max_clks; i++) begin
         @(negedge clk);
         if (bus_if.dma_n === 1'b1) begin
            r_rel = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      vectors++; if (bus_if.dma_n !== 1'b1) begin miscompares++; $display("FAIL reset_dma_n: got %b want 1", bus_if.dma_n); end
      vectors++; if (bus_if.bus_a_oe !== 1'b0) begin miscompares++; $display("FAIL reset_a_oe: got %b want 0", bus_if.bus_a_oe); end
      vectors++; if (bus_if.bus_d_oe !== 1'b0) begin miscompares++; $display("FAIL reset_d_oe: got %b want 0", bus_if.bus_d_oe); end
      vectors++; if (bus_if.bus_a_out !== 16'h0000) begin miscompares++; $display("FAIL reset_a_out: got %h want 0000", bus_if.bus_a_out); end
      vectors++; if (bus_if.bus_rw_out !== 1'b1) begin miscompares++; $display("FAIL reset_rw_out: got %b want 1", bus_if.bus_rw_out); end
      vectors++; if (bus_if.bus_d_out !== 8'h00) begin miscompares++; $display("FAIL reset_d_out: got %h want 00", bus_if.bus_d_out); end
      vectors++; if (bus_if.dma_q !== 8'h00) begin miscompares++; $display("FAIL reset_dma_q: got %h want 00", bus_if.dma_q); end
      vectors++; if (bus_if.dma_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", bus_if.dma_ack); end
      reset = 1'b0;
      repeat (5) @(negedge clk);
      vectors++; if (bus_if.dma_n !== 1'b1) begin miscompares++; $display("FAIL idle_dma_n: got %b want 1", bus_if.dma_n); end
   endtask

   task automatic test_read();
      bus_if.ba = 1'b1; bus_if.dma_rw = 1'b0; bus_if.dma_a = 16'hD020; bus_if.bus_d_in = 8'h5A;
      start_aligned();
      run_transfer(5000);
      vectors++; if (!r_ok) begin miscompares++; $display("FAIL read_ack_timeout: got no ack want ack"); end
      vectors++; if (r_nhigh !== 0) begin miscompares++; $display("FAIL read_dma_n_low: got %0d high clks want 0", r_nhigh); end
      vectors++; if (r_falls !== 3) begin miscompares++; $display("FAIL read_arm_falls: got %0d want 3", r_falls); end
      vectors++; if (r_oe_clks !== 25) begin miscompares++; $display("FAIL read_a_oe_clks: got %0d want 25", r_oe_clks); end
      vectors++; if (r_rw !== 1'b1) begin miscompares++; $display("FAIL read_rw_out: got %b want 1", r_rw); end
      vectors++; if (r_aout !== 16'hD020) begin miscompares++; $display("FAIL read_a_out: got %h want d020", r_aout); end
      vectors++; if (r_doe_clks !== 0) begin miscompares++; $display("FAIL read_d_oe: got %0d clks want 0", r_doe_clks); end
      vectors++; if (bus_if.dma_q !== 8'h5A) begin miscompares++; $display("FAIL read_dma_q: got %h want 5a", bus_if.dma_q); end
      vectors++; if (bus_if.dma_ack !== exp_ack) begin miscompares++; $display("FAIL read_ack: got %b want %b", bus_if.dma_ack, exp_ack); end
      vectors++; if (r_ack_oe !== 1'b0 || r_prev_oe !== 1'b1) begin miscompares++; $display("FAIL read_oe_vs_ack: got oe_at_ack=%b oe_before=%b want 0/1", r_ack_oe, r_prev_oe); end
      wait_release(500);
      vectors++; if (r_rel !== 64) begin miscompares++; $display("FAIL read_release: got %0d clks want 64", r_rel); end
   endtask

   task automatic test_write();
      bus_if.dma_rw = 1'b1; bus_if.dma_a = 16'h0400; bus_if.dma_d = 8'hA5; bus_if.bus_d_in = 8'hFF;
      start_aligned();
      run_transfer(5000);
      vectors++; if (!r_ok) begin miscompares++; $display("FAIL write_ack_timeout: got no ack want ack"); end
      vectors++; if (r_doe_clks !== 25) begin miscompares++; $display("FAIL write_d_oe_clks: got %0d want 25", r_doe_clks); end
      vectors++; if (r_dout !== 8'hA5) begin miscompares++; $display("FAIL write_d_out: got %h want a5", r_dout); end
      vectors++; if (r_rw !== 1'b0) begin miscompares++; $display("FAIL write_rw_out: got %b want 0", r_rw); end
      vectors++; if (r_aout !== 16'h0400) begin miscompares++; $display("FAIL write_a_out: got %h want 0400", r_aout); end
      vectors++; if (bus_if.dma_q !== 8'h5A) begin miscompares++; $display("FAIL write_q_hold: got %h want 5a", bus_if.dma_q); end
      vectors++; if (bus_if.dma_ack !== exp_ack) begin miscompares++; $display("FAIL write_ack: got %b want %b", bus_if.dma_ack, exp_ack); end
      vectors++; if (r_ack_oe !== 1'b0 || r_prev_oe !== 1'b1) begin miscompares++; $display("FAIL write_oe_vs_ack: got oe_at_ack=%b oe_before=%b want 0/1", r_ack_oe, r_prev_oe); end
      wait_release(500);
      vectors++; if (r_rel !== 64) begin miscompares++; $display("FAIL write_release: got %0d clks want 64", r_rel); end
   endtask

   task automatic test_ba_stall();
      int stall_oe;
      int stall_nhigh;
      int n;
      stall_oe = 0; stall_nhigh = 0; n = 0;
      bus_if.ba = 1'b0; bus_if.dma_rw = 1'b0; bus_if.dma_a = 16'h1000; bus_if.bus_d_in = 8'hC3;
      start_aligned();
      while (fall_cnt - b_f < 7 && n < 8000) begin
         @(negedge clk);
         n++;
         if (bus_if.bus_a_oe !== 1'b0 || bus_if.bus_d_oe !== 1'b0) stall_oe++;
         if (bus_if.dma_n !== 1'b0) stall_nhigh++;
      end
      bus_if.ba = 1'b1;
      vectors++; if (stall_oe !== 0) begin miscompares++; $display("FAIL ba_stall_oe: got %0d clks want 0", stall_oe); end
      vectors++; if (stall_nhigh !== 0) begin miscompares++; $display("FAIL ba_stall_dma_n: got %0d high clks want 0", stall_nhigh); end
      run_transfer(3000);
      vectors++; if (!r_ok) begin miscompares++; $display("FAIL ba_ack_timeout: got no ack want ack"); end
      vectors++; if (r_rises !== 7) begin miscompares++; $display("FAIL ba_cycle_rise: got rise %0d want 7", r_rises); end
      vectors++; if (bus_if.dma_q !== 8'hC3) begin miscompares++; $display("FAIL ba_dma_q: got %h want c3", bus_if.dma_q); end
      wait_release(500);
   endtask

   task automatic test_back_to_back();
      bus_if.dma_rw = 1'b0; bus_if.dma_a = 16'h2000; bus_if.bus_d_in = 8'h11;
      start_aligned();
      run_transfer(5000);
      vectors++; if (!r_ok) begin miscompares++; $display("FAIL b2b_first_timeout: got no ack want ack"); end
      repeat (10) @(negedge clk);
      bus_if.dma_a = 16'h1234; bus_if.bus_d_in = 8'h3C;
      toggle_req_now();
      run_transfer(2000);
      vectors++; if (!r_ok) begin miscompares++; $display("FAIL b2b_second_timeout: got no ack want ack"); end
      vectors++; if (r_clks + 10 !== 50) begin miscompares++; $display("FAIL b2b_ack_spacing: got %0d clks want 50", r_clks + 10); end
      vectors++; if (r_falls !== 0) begin miscompares++; $display("FAIL b2b_no_rearm: got %0d falls want 0", r_falls); end
      vectors++; if (r_nhigh !== 0) begin miscompares++; $display("FAIL b2b_dma_n: got %0d high clks want 0", r_nhigh); end
      vectors++; if (r_aout !== 16'h1234) begin miscompares++; $display("FAIL b2b_a_out: got %h want 1234", r_aout); end
      vectors++; if (bus_if.dma_q !== 8'h3C) begin miscompares++; $display("FAIL b2b_dma_q: got %h want 3c", bus_if.dma_q); end
      wait_release(500);
   endtask

   task automatic test_timeout_rearm();
      int nhigh;
      nhigh = 0;
      bus_if.dma_rw = 1'b0; bus_if.dma_a = 16'h3000; bus_if.bus_d_in = 8'h99;
      start_aligned();
      run_transfer(5000);
      vectors++; if (!r_ok) begin miscompares++; $display("FAIL tmo_first_timeout: got no ack want ack"); end
      repeat (63) begin
         @(negedge clk);
         if (bus_if.dma_n !== 1'b0) nhigh++;
      end
      bus_if.dma_a = 16'h3001; bus_if.bus_d_in = 8'h98;
      toggle_req_now();
      run_transfer(2000);
      vectors++; if (!r_ok) begin miscompares++; $display("FAIL tmo_second_timeout: got no ack want ack"); end
      vectors++; if (nhigh + r_nhigh !== 0) begin miscompares++; $display("FAIL tmo_expiry_pending: got %0d high clks want 0", nhigh + r_nhigh); end
      vectors++; if (bus_if.dma_q !== 8'h98) begin miscompares++; $display("FAIL tmo_second_q: got %h want 98", bus_if.dma_q); end
      wait_release(200);
      vectors++; if (r_rel !== 64) begin miscompares++; $display("FAIL tmo_release: got %0d clks want 64", r_rel); end
      if (r_rel > 0 && r_rel < 100) repeat (100 - r_rel) @(negedge clk);
      bus_if.dma_a = 16'h3002; bus_if.bus_d_in = 8'h97;
      toggle_req_now();
      run_transfer(6000);
      vectors++; if (!r_ok) begin miscompares++; $display("FAIL tmo_third_timeout: got no ack want ack"); end
      vectors++; if (r_falls !== 3) begin miscompares++; $display("FAIL tmo_rearm_falls: got %0d want 3", r_falls); end
      vectors++; if (bus_if.dma_q !== 8'h97) begin miscompares++; $display("FAIL tmo_third_q: got %h want 97", bus_if.dma_q); end
      wait_release(500);
   endtask

   task automatic test_reset_mid_cycle();
      int n;
      n = 0;
      bus_if.dma_rw = 1'b1; bus_if.dma_a = 16'h5555; bus_if.dma_d = 8'hE7;
      start_aligned();
      while (bus_if.bus_d_oe !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      vectors++; if (bus_if.bus_d_oe !== 1'b1) begin miscompares++; $display("FAIL rst_mid_d_oe_seen: got %b want 1", bus_if.bus_d_oe); end
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      vectors++; if (bus_if.dma_n !== 1'b1) begin miscompares++; $display("FAIL rst_mid_dma_n: got %b want 1", bus_if.dma_n); end
      vectors++; if (bus_if.bus_a_oe !== 1'b0 || bus_if.bus_d_oe !== 1'b0) begin miscompares++; $display("FAIL rst_mid_oe: got a=%b d=%b want 0/0", bus_if.bus_a_oe, bus_if.bus_d_oe); end
      vectors++; if (bus_if.dma_ack !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ack: got %b want 0", bus_if.dma_ack); end
      vectors++; if (bus_if.bus_d_out !== 8'h00) begin miscompares++; $display("FAIL rst_mid_d_out: got %h want 00", bus_if.bus_d_out); end
      bus_if.dma_req = 1'b0;
      exp_ack = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus_if.dma_n !== 1'b1) n++;
      end
      vectors++; if (n !== 0) begin miscompares++; $display("FAIL rst_mid_idle: got %0d low clks want 0", n); end
      bus_if.dma_rw = 1'b0; bus_if.dma_a = 16'hC000; bus_if.bus_d_in = 8'h77;
      start_aligned();
      run_transfer(5000);
      vectors++; if (!r_ok) begin miscompares++; $display("FAIL rst_fresh_timeout: got no ack want ack"); end
      vectors++; if (r_falls !== 3) begin miscompares++; $display("FAIL rst_fresh_falls: got %0d want 3", r_falls); end
      vectors++; if (bus_if.dma_q !== 8'h77) begin miscompares++; $display("FAIL rst_fresh_q: got %h want 77", bus_if.dma_q); end
      vectors++; if (bus_if.dma_ack !== 1'b1) begin miscompares++; $display("FAIL rst_fresh_ack: got %b want 1", bus_if.dma_ack); end
   endtask

   initial begin
      reset = 1'b1;
      bus_if.dma_a = 16'h0000;
      bus_if.dma_d = 8'h00;
      bus_if.dma_rw = 1'b0;
      bus_if.dma_req = 1'b0;
      bus_if.ba = 1'b1;
      bus_if.bus_d_in = 8'h00;
      test_reset();
      test_read();
      test_write();
      test_ba_stall();
      test_back_to_back();
      test_timeout_rearm();
      test_reset_mid_cycle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
